// File: rtl/bcd_to_binary8.sv
// bcd_to_binary8: sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
//
// Ports:
//   i_clk      - single clock, all state changes on the rising edge
//   i_rst_n    - synchronous active-low reset
//   i_start    - conversion request, sampled only in StIdle
//   i_bcd_in   - {hundreds[9:8], tens[7:4], units[3:0]}
//   o_bin_out  - registered binary result, held until the next completion
//   o_busy     - high while shifting (8 cycles per valid request)
//   o_done     - one-cycle completion pulse
//   o_err      - registered, high when the last accepted request was invalid
module bcd_to_binary8 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [9:0] i_bcd_in,
  output logic [7:0] o_bin_out,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic [9:0]  r_bcd, w_bcd_nxt;
  logic [7:0]  r_work, w_work_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_bin, w_bin_nxt;
  logic        r_err, w_err_nxt;

  // Input validity: digits must be decimal and the value must fit in 8 bits.
  logic [1:0]  w_hund;
  logic [3:0]  w_tens, w_units;
  logic [7:0]  w_tens_units;
  logic        w_valid;

  assign w_hund       = i_bcd_in[9:8];
  assign w_tens       = i_bcd_in[7:4];
  assign w_units      = i_bcd_in[3:0];
  // tens*10 + units; only meaningful when both digits are <= 9
  assign w_tens_units = ({4'd0, w_tens} << 3) + ({4'd0, w_tens} << 1) + {4'd0, w_units};
  assign w_valid      = (w_tens <= 4'd9) && (w_units <= 4'd9) && (w_hund != 2'd3) &&
                        !((w_hund == 2'd2) && (w_tens_units > 8'd55));

  // One shift step: {bcd, work} >> 1, then subtract 3 from any digit that is >= 8.
  logic [9:0]  w_sh_bcd;
  logic [7:0]  w_sh_work;
  logic [9:0]  w_fix_bcd;

  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  assign w_sh_bcd  = {1'b0, r_bcd[9:1]};
  assign w_sh_work = {r_bcd[0], r_work[7:1]};

  always_comb begin
    w_fix_bcd[3:0] = fix_digit(w_sh_bcd[3:0]);
    w_fix_bcd[7:4] = fix_digit(w_sh_bcd[7:4]);
    // Hundreds is zero-extended for the compare; after a shift it can never reach 8.
    w_fix_bcd[9:8] = ({2'b00, w_sh_bcd[9:8]} >= 4'd8) ? (w_sh_bcd[9:8] - 2'd3) : w_sh_bcd[9:8];
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_valid) begin
            w_bcd_nxt   = i_bcd_in;
            w_work_nxt  = 8'd0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = StShift;
          end else begin
            w_bin_nxt   = 8'd0;
            w_err_nxt   = 1'b1;
            w_state_nxt = StDone;
          end
        end
      end
      StShift: begin
        w_bcd_nxt  = w_fix_bcd;
        w_work_nxt = w_sh_work;
        w_cnt_nxt  = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_bin_nxt   = w_sh_work;
          w_err_nxt   = 1'b0;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_bcd   <= 10'd0;
      r_work  <= 8'd0;
      r_cnt   <= 3'd0;
      r_bin   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_bin_out = r_bin;
  assign o_err     = r_err;
  assign o_busy    = (r_state == StShift);
  assign o_done    = (r_state == StDone);

endmodule

// File: tb/tb_bcd_to_binary8.sv
// Self-checking bench for bcd_to_binary8 with an arithmetic reference model.
module tb_bcd_to_binary8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] bcd_in;
  logic [7:0] bin_out;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_binary8 dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_bcd_in  (bcd_in),
    .o_bin_out (bin_out),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  // Reference: decimal value of the digits; legal when digits <= 9 and value <= 255.
  function automatic void ref_model(input logic [9:0] code, output logic [7:0] exp_bin,
                                    output logic exp_err);
    int h, t, u, v;
    h = int'(code[9:8]);
    t = int'(code[7:4]);
    u = int'(code[3:0]);
    v = h * 100 + t * 10 + u;
    if (t > 9 || u > 9 || v > 255) begin
      exp_bin = 8'd0;
      exp_err = 1'b1;
    end else begin
      exp_bin = v[7:0];
      exp_err = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE; lat = edges after the accepting edge until done is seen.
  task automatic run_conv(input logic [9:0] code, output logic [7:0] got_bin,
                          output logic got_err, output int lat, output int nbusy);
    bcd_in = code;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 0;
    nbusy  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
    got_bin = bin_out;
    got_err = err;
    if (done !== 1'b1) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] b;
    logic       e;
    int         lat, nb;
    rst_n  = 1'b0;
    start  = 1'b1;
    bcd_in = 10'h255;
    repeat (3) tick();
    n_cmp++; if (bin_out !== 8'h00) begin n_bad++; $display("FAIL reset_bin got=%h exp=00", bin_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    // First edge with rst_n=1 and start=1 must accept.
    rst_n = 1'b1;
    run_conv(10'h255, b, e, lat, nb);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL first_req_lat got=%0d exp=8", lat); end
    n_cmp++; if (b !== 8'hFF) begin n_bad++; $display("FAIL first_req_bin got=%h exp=ff", b); end
  endtask

  task automatic test_directed();
    logic [9:0] codes [5] = '{10'h255, 10'h000, 10'h099, 10'h128, 10'h200};
    logic [7:0] exps  [5] = '{8'hFF, 8'h00, 8'h63, 8'h80, 8'hC8};
    logic [7:0] b;
    logic       e;
    int         lat, nb;
    for (int i = 0; i < 5; i++) begin
      run_conv(codes[i], b, e, lat, nb);
      n_cmp++; if (b !== exps[i]) begin n_bad++; $display("FAIL dir_bin code=%h got=%h exp=%h", codes[i], b, exps[i]); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL dir_err code=%h got=%b exp=0", codes[i], e); end
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL dir_lat code=%h got=%0d exp=8", codes[i], lat); end
      n_cmp++; if (nb !== 8) begin n_bad++; $display("FAIL dir_busy code=%h got=%0d exp=8", codes[i], nb); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dir_done_len code=%h got=%b exp=0", codes[i], done); end
    end
    repeat (3) tick();
    n_cmp++; if (bin_out !== 8'hC8) begin n_bad++; $display("FAIL dir_hold got=%h exp=c8", bin_out); end
  endtask

  task automatic test_invalid();
    logic [9:0] codes [4] = '{10'h256, 10'h0A0, 10'h00F, 10'h300};
    logic [7:0] b;
    logic       e;
    int         lat, nb;
    for (int i = 0; i < 4; i++) begin
      run_conv(codes[i], b, e, lat, nb);
      n_cmp++; if (b !== 8'h00) begin n_bad++; $display("FAIL inv_bin code=%h got=%h exp=00", codes[i], b); end
      n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL inv_err code=%h got=%b exp=1", codes[i], e); end
      n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL inv_lat code=%h got=%0d exp=0", codes[i], lat); end
      n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL inv_busy code=%h got=%0d exp=0", codes[i], nb); end
    end
    repeat (3) tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err_hold got=%b exp=1", err); end
  endtask

  task automatic test_ignore_start();
    int         ndone = 0;
    int         nbusy = 0;
    logic [7:0] b = 8'h00;
    bcd_in = 10'h123;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) begin start = 1'b1; bcd_in = 10'h045; end
      if (i == 3) begin start = 1'b0; bcd_in = 10'h300; end
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++;
        b = bin_out;
        start = 1'b1;  // pulse during DONE: must be ignored
      end else if (i > 3) begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL ign_ndone got=%0d exp=1", ndone); end
    n_cmp++; if (nbusy !== 8) begin n_bad++; $display("FAIL ign_nbusy got=%0d exp=8", nbusy); end
    n_cmp++; if (b !== 8'h7B) begin n_bad++; $display("FAIL ign_bin got=%h exp=7b", b); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ign_err got=%b exp=0", err); end
  endtask

  task automatic test_mid_reset();
    int         ndone = 0;
    logic [7:0] b;
    logic       e;
    int         lat, nb;
    bcd_in = 10'h255;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    n_cmp++; if (bin_out !== 8'h00) begin n_bad++; $display("FAIL mrst_bin got=%h exp=00", bin_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done got=%b exp=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mrst_err got=%b exp=0", err); end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL mrst_nodone got=%0d exp=0", ndone); end
    run_conv(10'h042, b, e, lat, nb);
    n_cmp++; if (b !== 8'h2A) begin n_bad++; $display("FAIL mrst_042_bin got=%h exp=2a", b); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL mrst_042_lat got=%0d exp=8", lat); end
  endtask

  task automatic test_back_to_back();
    int         pos[$];
    logic [9:0] code;
    logic [7:0] exp_bin;
    logic       exp_err;
    code = {2'd1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    ref_model(code, exp_bin, exp_err);
    bcd_in = code;
    start  = 1'b1;
    for (int i = 1; i <= 39; i++) begin
      tick();
      if (done === 1'b1) begin
        pos.push_back(i);
        n_cmp++; if (bin_out !== exp_bin) begin n_bad++; $display("FAIL b2b_bin code=%h got=%h exp=%h", code, bin_out, exp_bin); end
      end
    end
    start = 1'b0;
    tick();
    n_cmp++; if (pos.size() !== 4) begin n_bad++; $display("FAIL b2b_count got=%0d exp=4", pos.size()); end
    for (int k = 1; k < pos.size(); k++) begin
      n_cmp++; if (pos[k] - pos[k-1] !== 10) begin n_bad++; $display("FAIL b2b_period got=%0d exp=10", pos[k] - pos[k-1]); end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] b, exp_bin;
    logic       e, exp_err;
    int         lat, nb;
    for (int c = 0; c < 1024; c++) begin
      run_conv(10'(c), b, e, lat, nb);
      ref_model(10'(c), exp_bin, exp_err);
      n_cmp++; if (b !== exp_bin) begin n_bad++; $display("FAIL exh_bin code=%h got=%h exp=%h", c, b, exp_bin); end
      n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL exh_err code=%h got=%b exp=%b", c, e, exp_err); end
      n_cmp++; if (lat !== (exp_err ? 0 : 8)) begin n_bad++; $display("FAIL exh_lat code=%h got=%0d exp=%0d", c, lat, exp_err ? 0 : 8); end
    end
  endtask

  task automatic test_random();
    logic [9:0] code;
    logic [7:0] b, exp_bin;
    logic       e, exp_err;
    int         lat, nb;
    for (int n = 0; n < 300; n++) begin
      code = 10'($urandom_range(0, 1023));
      run_conv(code, b, e, lat, nb);
      ref_model(code, exp_bin, exp_err);
      n_cmp++; if (b !== exp_bin) begin n_bad++; $display("FAIL rnd_bin code=%h got=%h exp=%h", code, b, exp_bin); end
      n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL rnd_err code=%h got=%b exp=%b", code, e, exp_err); end
      n_cmp++; if (nb !== (exp_err ? 0 : 8)) begin n_bad++; $display("FAIL rnd_busy code=%h got=%0d exp=%0d", code, nb, exp_err ? 0 : 8); end
      bcd_in = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 3)) tick();
      n_cmp++; if (bin_out !== exp_bin) begin n_bad++; $display("FAIL rnd_hold code=%h got=%h exp=%h", code, bin_out, exp_bin); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 10'd0;
    test_reset();
    test_directed();
    test_invalid();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary8.md
BCD_TO_BINARY8 -- requirements
Module: bcd_to_binary8

Interface
- No parameters; widths are fixed.
- REQ-001: clk  input  1  single clock; all state changes on rising edge.
- REQ-002: rst_n  input  1  reset, synchronous, active-low.
- REQ-003: start  input  1  request to convert bcd_in; sampled only in IDLE.
- REQ-004: bcd_in  input  10  3-digit BCD {hundreds[9:8], tens[7:4], units[3:0]}; same packing as the team's 8-bit binary-to-BCD output.
- REQ-005: bin_out  output  8  registered binary result.
- REQ-006: busy  output  1  high while conversion is in progress (SHIFT state).
- REQ-007: done  output  1  one-cycle completion pulse (DONE state).
- REQ-008: err  output  1  registered; high when the last accepted request was invalid.

Function
- REQ-009: Sequential reverse double-dabble; FSM states are IDLE, SHIFT and DONE.
- REQ-010: IDLE with start=1 and valid bcd_in on edge E0 captures bcd_in into an internal 10-bit register, clears the 8-bit work register and shift counter, and goes to SHIFT.
- REQ-011: Validity rule: tens<=9 and units<=9 and value<=255. Invalid cases are hundreds=3, hundreds=2 with tens*10+units>55, or any digit>9.
- REQ-012: IDLE with start=1 and invalid bcd_in on E0 goes directly to DONE with bin_out=0x00 and err=1.
- REQ-013: Each SHIFT edge (E1..E8) does two things:
  - shifts {bcd_reg, work} right by 1 as one 18-bit value, with the bcd_reg LSB entering the work MSB;
  - then subtracts 3 from each 4-bit BCD digit whose shifted value is >=8.
- REQ-014: Digit correction uses 4-bit arithmetic per digit only, with no carry between digits; the hundreds field is zero-extended to 4 bits for the compare.
- REQ-015: On E8 (counter reaches 7), bin_out loads work, err goes to 0, and the FSM goes to DONE.
- REQ-016: Latency for a valid request: done is high in the cycle after E8, i.e. 8 edges after E0; busy is high for exactly 8 cycles.
- REQ-017: Latency for an invalid request: done is high in the cycle after E0; busy stays low.
- REQ-018: DONE lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
- REQ-019: start is ignored in SHIFT and DONE; start is not queued.
- REQ-020: A new request is accepted no earlier than the cycle after done drops.
- REQ-021: bcd_in changes after E0 have no effect on the result.
- REQ-022: bin_out and err hold their values until the next completion, valid or invalid; they remain stable in IDLE.
- REQ-023: start held high continuously produces back-to-back conversions: one accepted in every IDLE cycle, with period 10 cycles for valid input.

Reset
- REQ-024: rst_n=0 at a rising edge sets: state=IDLE, bin_out=0x00, busy=0, done=0, err=0, internal registers=0.
- REQ-025: Reset applied mid-conversion aborts the conversion; no done pulse is produced for it.
- REQ-026: start is ignored on any edge where rst_n=0.
- REQ-027: The first request is accepted on the first edge with rst_n=1 and start=1.

Verification
- REQ-028: bcd_in=10'b10_0101_0101 (255), start pulse -> busy high 8 cycles, then done=1 one cycle with bin_out=0xFF and err=0.
- REQ-029: Values 000 / 099 / 128 / 200 -> bin_out 0x00 / 0x63 / 0x80 / 0xC8 respectively, each with done exactly 8 edges after accept.
- REQ-030: Invalid inputs 256 (10'b10_0101_0110), tens=0xA, units=0xF, hundreds=3 -> done one cycle after start, err=1, bin_out=0x00, busy never high.
- REQ-031: Pulse start again during SHIFT and change bcd_in after E0 -> no extra done pulse, and the result matches the originally captured value.
- REQ-032: Drive rst_n=0 on the 4th SHIFT edge -> next cycle all outputs 0 with state IDLE, no done pulse; a subsequent request for 042 yields bin_out=0x2A.
- REQ-033: Exhaustive sweep of all 1024 bcd_in codes -> bin_out equals the decimal value and err=0 for the 256 legal codes; err=1 and bin_out=0 for all others.
